// File: rtl/piso_seq_ctrl.sv
// Parallel-in/serial-out sequencer: captures a word over valid/ready, then shifts it out one bit per shift_en tick.
// Define PISO_PARITY_EN to append an even-parity bit after the last data bit.
module piso_seq_ctrl #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_DONE   = 2'd3
  } state_t;
  logic r_parity;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd3
  } state_t;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_bitcnt;
  logic             r_sout;
  logic             r_sout_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_load_ready;

  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_shifted;
  logic             w_last;

  // sout is registered, so the bit that becomes visible after a shift is picked one position in.
  assign w_first_bit = MSB_FIRST ? data[WIDTH-1] : data[0];
  assign w_next_bit  = MSB_FIRST ? r_shreg[WIDTH-2] : r_shreg[1];
  assign w_shifted   = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};
  assign w_last      = (r_bitcnt == CW'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (!reset_) begin
      r_state      <= S_IDLE;
      r_shreg      <= '0;
      r_bitcnt     <= '0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_load_ready <= 1'b0;
`ifdef PISO_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load_valid && r_load_ready) begin
            r_state      <= S_SHIFT;
            r_shreg      <= data;
            r_bitcnt     <= '0;
            r_sout       <= w_first_bit;
            r_sout_valid <= 1'b1;
            r_busy       <= 1'b1;
            r_load_ready <= 1'b0;
`ifdef PISO_PARITY_EN
            r_parity     <= ^data;
`endif
          end else begin
            r_load_ready <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (shift_en) begin
            r_shreg  <= w_shifted;
            r_bitcnt <= r_bitcnt + CW'(1);
            if (w_last) begin
`ifdef PISO_PARITY_EN
              r_state      <= S_PARITY;
              r_sout       <= r_parity;
`else
              r_state      <= S_DONE;
              r_sout       <= 1'b0;
              r_sout_valid <= 1'b0;
              r_done       <= 1'b1;
`endif
            end else begin
              r_sout <= w_next_bit;
            end
          end
        end
`ifdef PISO_PARITY_EN
        S_PARITY: begin
          if (shift_en) begin
            r_state      <= S_DONE;
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_done       <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          r_state      <= S_IDLE;
          r_done       <= 1'b0;
          r_busy       <= 1'b0;
          r_load_ready <= 1'b1;
        end
        default: begin
          r_state      <= S_IDLE;
          r_sout       <= 1'b0;
          r_sout_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
          r_load_ready <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready = r_load_ready;
  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
